// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory controller sitting between a boot loader, the
//   fetch stage and a synchronous single-port instruction RAM.
// Latency: loader writes reach the RAM in the cycle they are offered; fetch
//   results appear one cycle after acceptance (RAM read latency).
// Backpressure: loader writes always win the RAM port; a fetch that loses
//   arbitration, arrives outside RUN, or is out of range sees stall=1.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   fetch_req/addr    fetch request and byte address
//   fetch_valid/instr one-cycle-delayed fetch result (NOP when not valid)
//   stall             fetch request not accepted this cycle
//   ld_valid/ready    loader write handshake
//   ld_addr/data/last loader byte address, word and end-of-image marker
//   mem_we/addr/wdata RAM write strobe, word index, write data
//   mem_rdata         RAM read data, valid the cycle after mem_addr
//   run/fault         decoded state
//   ld_err            sticky out-of-range load flag
//   ld_count          words written to the RAM (saturating)
module imem_ctrl #(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int              MEM_SIZE     = 256,
  localparam int             AW           = $clog2(MEM_SIZE)
) (
  input  logic            clk,
  input  logic            rst,

  // fetch side
  input  logic            fetch_req,
  input  logic [SIZE-1:0] fetch_addr,
  output logic            fetch_valid,
  output logic [SIZE-1:0] fetch_instr,
  output logic            stall,

  // loader side
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [SIZE-1:0] ld_addr,
  input  logic [SIZE-1:0] ld_data,
  input  logic            ld_last,

  // memory side
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,

  // status
  output logic            run,
  output logic            fault,
  output logic            ld_err,
  output logic [AW:0]     ld_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] NOP       = SIZE'(32'h0000_0013);
  localparam logic [SIZE-1:0] MEM_LIMIT = SIZE'(MEM_SIZE);
  localparam logic [AW:0]     LD_MAX    = (AW+1)'(MEM_SIZE);

  state_t          state, state_nxt;
  logic [AW:0]     ld_count_nxt;
  logic            ld_err_nxt;
  logic            fetch_valid_nxt;

  // Address decode: offsets are taken modulo 2^SIZE, so addresses below
  // BASE_ADDRESS wrap to huge offsets and fall out of range naturally.
  logic [SIZE-1:0] ld_off, fetch_off;
  logic [AW-1:0]   ld_idx, fetch_idx;
  logic            ld_in_range, fetch_in_range;

  assign ld_off         = ld_addr - BASE_ADDRESS;
  assign fetch_off      = fetch_addr - BASE_ADDRESS;
  assign ld_idx         = ld_off[AW+1:2];
  assign fetch_idx      = fetch_off[AW+1:2];
  assign ld_in_range    = (ld_off[1:0] == 2'b00) && ((ld_off >> 2) < MEM_LIMIT);
  assign fetch_in_range = (fetch_off[1:0] == 2'b00) && ((fetch_off >> 2) < MEM_LIMIT);

  // Next-state and output decode
  always_comb begin
    state_nxt       = state;
    ld_count_nxt    = ld_count;
    ld_err_nxt      = ld_err;
    fetch_valid_nxt = 1'b0;
    ld_ready        = 1'b0;
    stall           = fetch_req;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    // While rst is high nothing is accepted, so no RAM write can slip
    // through in the reset cycle.
    if (!rst) begin
      unique case (state)
        BOOT: begin
          ld_ready = 1'b1;
          if (ld_valid && ld_last) begin
            state_nxt = RUN;
          end
        end

        RUN: begin
          ld_ready = 1'b1;
          // A pending loader write owns the RAM port; the fetch stays stalled.
          if (!ld_valid && fetch_req) begin
            if (fetch_in_range) begin
              stall           = 1'b0;
              mem_addr        = fetch_idx;
              fetch_valid_nxt = 1'b1;
            end else begin
              state_nxt = FAULT;
            end
          end
        end

        FAULT: begin
          // Terminal until reset: loader blocked, every fetch stalled.
        end

        default: begin
          state_nxt = BOOT;
        end
      endcase

      // Loader handshake, common to BOOT and RUN
      if (ld_valid && ld_ready) begin
        if (ld_in_range) begin
          mem_we    = 1'b1;
          mem_addr  = ld_idx;
          mem_wdata = ld_data;
          if (ld_count != LD_MAX) begin
            ld_count_nxt = ld_count + 1'b1;
          end
        end else begin
          ld_err_nxt = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      ld_count    <= '0;
      ld_err      <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld_count    <= ld_count_nxt;
      ld_err      <= ld_err_nxt;
      fetch_valid <= fetch_valid_nxt;
    end
  end

  assign fetch_instr = fetch_valid ? mem_rdata : NOP;
  assign run         = (state == RUN);
  assign fault       = (state == FAULT);

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;

  localparam int          SIZE = 32;
  localparam int          AW   = 8;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_req;
  logic [SIZE-1:0] fetch_addr;
  logic            fetch_valid;
  logic [SIZE-1:0] fetch_instr;
  logic            stall;
  logic            ld_valid;
  logic            ld_ready;
  logic [SIZE-1:0] ld_addr;
  logic [SIZE-1:0] ld_data;
  logic            ld_last;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [SIZE-1:0] mem_wdata;
  logic [SIZE-1:0] mem_rdata;
  logic            run;
  logic            fault;
  logic            ld_err;
  logic [AW:0]     ld_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0020_81B3, 32'h0000_006F};

  always #5 clk = ~clk;

  imem_ctrl #(.SIZE(32), .BASE_ADDRESS(32'h0), .MEM_SIZE(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .stall       (stall),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .run         (run),
    .fault       (fault),
    .ld_err      (ld_err),
    .ld_count    (ld_count)
  );

  // Synchronous RAM behind the controller
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    ld_last    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%0b exp=0", run); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid got=%0b exp=0", fetch_valid); end
    checks++; if (fetch_instr !== NOP) begin failures++; $display("FAIL reset_fetch_instr got=%h exp=%h", fetch_instr, NOP); end
    checks++; if (ld_count !== 9'd0) begin failures++; $display("FAIL reset_ld_count got=%0d exp=0", ld_count); end
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL reset_ld_err got=%0b exp=0", ld_err); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_boot_ld_ready got=%0b exp=1", ld_ready); end
    checks++; if (mem_we !== 1'b0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_idle we=%0b wdata=%h exp we=0 wdata=0", mem_we, mem_wdata); end
  endtask

  task automatic test_bad_load();
    @(negedge clk);
    ld_valid   = 1'b1;
    ld_addr    = 32'h400;
    ld_data    = 32'hCAFE_F00D;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL bad_load_ready got=%0b exp=1", ld_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL bad_load_we got=%0b exp=0", mem_we); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL bad_load_wdata got=%h exp=0", mem_wdata); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL boot_fetch_stall got=%0b exp=1", stall); end
    @(posedge clk); #1;
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL bad_load_err got=%0b exp=1", ld_err); end
    checks++; if (ld_count !== 9'd0) begin failures++; $display("FAIL bad_load_count got=%0d exp=0", ld_count); end
    checks++; if (run !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL bad_load_state run=%0b fv=%0b exp 0 0", run, fetch_valid); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL bad_load_err_sticky got=%0b exp=1", ld_err); end
  endtask

  task automatic test_boot_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = 32'(i * 4);
      ld_data  = words[i];
      ld_last  = (i == 3);
      #1;
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL boot_we[%0d] got=%0b exp=1", i, mem_we); end
      checks++; if (mem_addr !== 8'(i)) begin failures++; $display("FAIL boot_addr[%0d] got=%0d exp=%0d", i, mem_addr, i); end
      checks++; if (mem_wdata !== words[i]) begin failures++; $display("FAIL boot_wdata[%0d] got=%h exp=%h", i, mem_wdata, words[i]); end
      checks++; if (run !== 1'b0) begin failures++; $display("FAIL boot_run_early[%0d] got=%0b exp=0", i, run); end
    end
    @(posedge clk); #1;
    checks++; if (run !== 1'b1) begin failures++; $display("FAIL boot_run got=%0b exp=1", run); end
    checks++; if (ld_count !== 9'd4) begin failures++; $display("FAIL boot_count got=%0d exp=4", ld_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", k, fetch_valid); end
        checks++; if (fetch_instr !== words[k-1]) begin failures++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", k, fetch_instr, words[k-1]); end
      end
      if (k < 3) begin
        fetch_req  = 1'b1;
        fetch_addr = 32'(k * 4);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall[%0d] got=%0b exp=0", k, stall); end
        checks++; if (mem_addr !== 8'(k)) begin failures++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", k, mem_addr, k); end
      end else begin
        idle_inputs();
      end
    end
    @(negedge clk);
    checks++; if (fetch_valid !== 1'b0 || fetch_instr !== NOP) begin failures++; $display("FAIL b2b_drain fv=%0b instr=%h exp 0 %h", fetch_valid, fetch_instr, NOP); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    ld_valid   = 1'b1;
    ld_addr    = 32'h10;
    ld_data    = 32'hDEAD_BEEF;
    ld_last    = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd4) begin failures++; $display("FAIL coll_write we=%0b addr=%0d exp 1 4", mem_we, mem_addr); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL coll_stall got=%0b exp=1", stall); end
    @(negedge clk);
    checks++; if (fetch_valid !== 1'b0 || fetch_instr !== NOP) begin failures++; $display("FAIL coll_no_valid fv=%0b instr=%h exp 0 %h", fetch_valid, fetch_instr, NOP); end
    checks++; if (run !== 1'b1) begin failures++; $display("FAIL coll_ld_last_ignored run=%0b exp=1", run); end
    checks++; if (ld_count !== 9'd5) begin failures++; $display("FAIL coll_count got=%0d exp=5", ld_count); end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL coll_retry_stall got=%0b exp=0", stall); end
    @(negedge clk);
    checks++; if (fetch_valid !== 1'b1 || fetch_instr !== words[0]) begin failures++; $display("FAIL coll_retry fv=%0b instr=%h exp 1 %h", fetch_valid, fetch_instr, words[0]); end
    fetch_addr = 32'h10;
    @(negedge clk);
    checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL coll_written_word fv=%0b instr=%h exp 1 deadbeef", fetch_valid, fetch_instr); end
    idle_inputs();
  endtask

  task automatic test_fault();
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 32'h402;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fault_stall got=%0b exp=1", stall); end
    @(posedge clk); #1;
    checks++; if (fault !== 1'b1 || run !== 1'b0) begin failures++; $display("FAIL fault_state fault=%0b run=%0b exp 1 0", fault, run); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL fault_no_valid got=%0b exp=0", fetch_valid); end
    @(negedge clk);
    fetch_addr = 32'h0;
    ld_valid   = 1'b1;
    ld_addr    = 32'h0;
    ld_data    = 32'h1234_5678;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fault_fetch_stall got=%0b exp=1", stall); end
    checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL fault_ld_blocked ready=%0b we=%0b exp 0 0", ld_ready, mem_we); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (fault !== 1'b1 || fetch_valid !== 1'b0) begin failures++; $display("FAIL fault_hold fault=%0b fv=%0b exp 1 0", fault, fetch_valid); end
    checks++; if (ld_count !== 9'd5) begin failures++; $display("FAIL fault_count got=%0d exp=5", ld_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mid_fault_cleared got=%0b exp=0", fault); end
    ld_valid = 1'b1;
    ld_addr  = 32'h0;
    ld_data  = 32'hA5A5_0001;
    ld_last  = 1'b1;
    @(negedge clk);
    idle_inputs();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    #1;
    checks++; if (run !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL mid_accept run=%0b stall=%0b exp 1 0", run, stall); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hA5A5_0001) begin failures++; $display("FAIL mid_pre_rst fv=%0b instr=%h exp 1 a5a50001", fetch_valid, fetch_instr); end
    @(posedge clk); #1;
    checks++; if (fetch_valid !== 1'b0 || fetch_instr !== NOP) begin failures++; $display("FAIL mid_rst_valid fv=%0b instr=%h exp 0 %h", fetch_valid, fetch_instr, NOP); end
    checks++; if (run !== 1'b0 || ld_count !== 9'd0) begin failures++; $display("FAIL mid_rst_state run=%0b count=%0d exp 0 0", run, ld_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_bad_load();
    test_reset();
    test_boot_load();
    test_back_to_back();
    test_collision();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 32: address/data width.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h00000000: byte address of word 0.
REQ-003 SHALL have parameter MEM_SIZE, default 256: depth of the instruction memory in 32-bit words; AW = $clog2(MEM_SIZE).
REQ-004 SHALL use one clock and a synchronous, active-high reset, named as follows:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
REQ-005 SHALL have the fetch-side ports:
- fetch_req  input  1  fetch stage requests an instruction
- fetch_addr  input  SIZE  byte address
- fetch_valid  output  1  fetch_instr is valid this cycle
- fetch_instr  output  SIZE  instruction word
- stall  output  1  request not accepted this cycle
REQ-006 SHALL have the loader-side ports:
- ld_valid  input  1  loader offers a write
- ld_ready  output  1  write accepted
- ld_addr  input  SIZE  byte address
- ld_data  input  SIZE  instruction word
- ld_last  input  1  final word of the boot image
REQ-007 SHALL have the memory-side ports:
- mem_we  output  1  write strobe
- mem_addr  output  AW  word index
- mem_wdata  output  SIZE  write data
- mem_rdata  input  SIZE  synchronous read data, valid the cycle after mem_addr
REQ-008 SHALL have the status ports:
- run  output  1  state is RUN
- fault  output  1  state is FAULT
- ld_err  output  1  sticky flag for an out-of-range load
- ld_count  output  AW+1  count of words written

Function
REQ-009 SHALL implement the states BOOT, RUN and FAULT; the state register, ld_count, ld_err and the fetch_valid register are the only sequential state.
REQ-010 Address mapping SHALL be: off = addr - BASE_ADDRESS; word index = off[AW+1:2]; an address is in range iff off[1:0]==0 and (off>>2) < MEM_SIZE.
REQ-011 In BOOT:
- ld_ready=1.
- stall = fetch_req.
- No fetch is accepted.
REQ-012 A load handshake (ld_valid & ld_ready) with ld_addr in range SHALL, in the same cycle:
- assert mem_we=1, with mem_addr = the word index and mem_wdata = ld_data;
- increment ld_count, saturating at MEM_SIZE.
REQ-013 A load handshake with ld_addr out of range SHALL:
- be consumed (ld_ready=1);
- keep mem_we=0;
- set ld_err=1, which holds until reset.
REQ-014 A load handshake with ld_last=1 in BOOT SHALL move the state to RUN on the next edge; ld_last SHALL be ignored in RUN.
REQ-015 In RUN, ld_ready=1 and loader writes SHALL keep priority: when ld_valid and fetch_req are both high, the write is performed, stall=1 and the fetch is not accepted.
REQ-016 In RUN, a fetch_req with ld_valid=0 and fetch_addr in range SHALL:
- be accepted with stall=0 and mem_addr = the word index;
- produce fetch_valid=1 exactly one cycle later, with fetch_instr = mem_rdata (1-cycle latency; back-to-back accepts give one result per cycle).
REQ-017 In RUN, a fetch_req with ld_valid=0 and fetch_addr out of range or misaligned SHALL:
- not be accepted (stall=1);
- move the state to FAULT on the next edge.
REQ-018 In FAULT:
- stall = fetch_req, ld_ready=0, mem_we=0;
- no state exit except reset.
REQ-019 When fetch_valid=0, fetch_instr SHALL equal 32'h00000013 (NOP).
REQ-020 When no write is performed, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-021 run and fault SHALL be decoded directly from the state register.

Reset
REQ-022 rst=1 at a clock edge SHALL set:
- state=BOOT, ld_count=0, ld_err=0, fetch_valid=0;
- hence run=0, fault=0, fetch_instr=32'h00000013.
REQ-023 rst SHALL override all other inputs in the same cycle.
REQ-024 Reset mid-load or mid-fetch SHALL drop any pending fetch_valid, and image loading SHALL restart in BOOT.

Verification
REQ-025 SHALL cover the boot load: 4 writes to 0x0,0x4,0x8,0xC (ld_last on the 4th) -> mem_we=1 on each, mem_addr 0..3, ld_count=4, run=1 after the 4th edge.
REQ-026 SHALL cover back-to-back fetches: in RUN, fetch 0x0,0x4,0x8 on consecutive cycles -> stall=0 on each, fetch_valid=1 on the 3 following cycles with the stored words in order.
REQ-027 SHALL cover a collision: in RUN, ld_valid and fetch_req both high (ld 0x10, fetch 0x0) -> mem_we=1, stall=1, no fetch_valid next cycle; the fetch retried next cycle succeeds.
REQ-028 SHALL cover a fault: fetch 0x402 (misaligned) in RUN -> stall=1, fault=1 next cycle; a later fetch 0x0 stays stalled and ld_ready=0 until rst.
REQ-029 SHALL cover a bad load: in BOOT, load to 0x400 with MEM_SIZE=256 -> ld_ready=1, mem_we=0, ld_err=1, ld_count unchanged.
REQ-030 SHALL cover reset mid-operation: rst asserted the cycle after an accepted fetch -> fetch_valid=0, state BOOT, ld_count=0 on the following cycle.
